// File: rtl/vdcorput_seq_gen.sv
// Van der Corput radical-inverse burst generator: for k, k+1, ... emits the base-b
// digit-reversed fraction of each index, one term per handshake.
module vdcorput_seq_gen #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 32,
  parameter int BASE_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  k_in,
  input  logic [BASE_W-1:0] base_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic              ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC-1:0]   result,
  output logic [WIDTH-1:0]  out_k,
  output logic              last,
  output logic              error
);

  localparam int PW = FRAC + 8;                    // weight carries 8 guard bits
  localparam int DW = (WIDTH > PW) ? WIDTH : PW;
  localparam int AW = PW + BASE_W;
  localparam int CW = $clog2(DW);
  localparam logic [PW:0] TWO_PW = {1'b1, {PW{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, DIV, ACC, EMIT, NEXT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   k_q, k_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      p_q, p_d;
  logic [DW-1:0]      kw_q, kw_d, pd_q, pd_d;
  logic [BASE_W-1:0]  rk_q, rk_d, rp_q, rp_d;
  logic [CW-1:0]      div_cnt_q, div_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [FRAC-1:0]    result_q, result_d;
  logic [WIDTH-1:0]   out_k_q, out_k_d;
  logic               last_q, last_d;
  logic               error_q, error_d;

  logic [BASE_W+DW-1:0] step_k, step_p;
  logic [AW-1:0]        acc_sum;
  logic [PW-1:0]        p_init, pn;

  // One restoring-division step: returns {remainder, shifted dividend with new quotient bit}.
  // After DW steps the dividend register holds the quotient.
  function automatic logic [BASE_W+DW-1:0] div_step(input logic [BASE_W-1:0] rem,
                                                    input logic [DW-1:0]     dv,
                                                    input logic [BASE_W-1:0] b);
    logic [BASE_W:0] t;
    logic            q;
    t = {rem, dv[DW-1]};
    q = (t >= {1'b0, b});
    if (q) t = t - {1'b0, b};
    return {t[BASE_W-1:0], dv[DW-2:0], q};
  endfunction

  function automatic logic [FRAC-1:0] sat(input logic [AW-1:0] a);
    return (|a[AW-1:PW]) ? '1 : FRAC'(a >> 8);
  endfunction

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    p_d         = p_q;
    kw_d        = kw_q;
    pd_d        = pd_q;
    rk_d        = rk_q;
    rp_d        = rp_q;
    div_cnt_d   = div_cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_k_d     = out_k_q;
    last_d      = last_q;
    error_d     = 1'b0;

    step_k  = div_step(rk_q, kw_q, base_q);
    step_p  = div_step(rp_q, pd_q, base_q);
    acc_sum = acc_q + AW'(rk_q) * AW'(p_q);
    p_init  = PW'(TWO_PW / (PW+1)'(base_q));
    pn      = pd_q[PW-1:0];

    case (state_q)
      IDLE: if (start) begin
        if (base_in >= BASE_W'(2)) begin
          k_d     = k_in;
          base_d  = base_in;
          cnt_d   = (count_in == '0) ? CNT_W'(1) : count_in;
          state_d = LOAD;
        end else begin
          error_d = 1'b1;
        end
      end
      LOAD: begin
        acc_d     = '0;
        p_d       = p_init;
        kw_d      = DW'(k_q);
        pd_d      = DW'(p_init);
        rk_d      = '0;
        rp_d      = '0;
        div_cnt_d = '0;
        state_d   = (k_q == '0) ? EMIT : DIV;
      end
      DIV: begin
        {rk_d, kw_d} = step_k;
        {rp_d, pd_d} = step_p;
        div_cnt_d    = div_cnt_q + 1'b1;
        if (div_cnt_q == CW'(DW-1)) state_d = ACC;
      end
      ACC: begin
        // kw/pd already hold the quotients, so they double as the next dividends
        acc_d     = acc_sum;
        p_d       = pn;
        rk_d      = '0;
        rp_d      = '0;
        div_cnt_d = '0;
        state_d   = (kw_q == '0 || pn == '0) ? EMIT : DIV;
      end
      EMIT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = (cnt_q == CNT_W'(1)) ? IDLE : NEXT;
      end
      NEXT: begin
        k_d     = k_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == EMIT && state_q != EMIT) begin
      out_valid_d = 1'b1;
      result_d    = sat(acc_d);
      out_k_d     = k_q;
      last_d      = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      kw_q        <= '0;
      pd_q        <= '0;
      rk_q        <= '0;
      rp_q        <= '0;
      div_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_k_q     <= '0;
      last_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      kw_q        <= kw_d;
      pd_q        <= pd_d;
      rk_q        <= rk_d;
      rp_q        <= rp_d;
      div_cnt_q   <= div_cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_k_q     <= out_k_d;
      last_q      <= last_d;
      error_q     <= error_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_k     = out_k_q;
  assign last      = last_q;
  assign error     = error_q;

endmodule

// File: tb/tb_vdcorput_seq_gen.sv
// Scoreboard bench for vdcorput_seq_gen: directed bursts push expected terms,
// a negedge monitor compares every presented term against the queue head.
module tb_vdcorput_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic [31:0] k_in;
  logic [3:0]  base_in;
  logic [15:0] count_in;
  logic        ready, out_valid, last, error;
  logic [31:0] result, out_k;

  always #5 clk = ~clk;

  vdcorput_seq_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_in(k_in), .base_in(base_in),
    .count_in(count_in), .ready(ready), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_k(out_k), .last(last), .error(error)
  );

  typedef struct { logic [31:0] k; logic [31:0] r; logic l; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] k, input logic [31:0] r, input logic l);
    exp_t e;
    e.k = k; e.r = r; e.l = l;
    sb.push_back(e);
  endtask

  // Called just after a posedge (or at a negedge); start is seen by the next edge.
  task automatic start_burst(input logic [31:0] k, input logic [3:0] b, input logic [15:0] c);
    k_in = k; base_in = b; count_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges from the start-sampling edge up to the one that raises out_valid.
  task automatic run_lat(input logic [31:0] k, input logic [3:0] b, input logic [15:0] c,
                         input int exp_lat);
    int cyc = 0;
    k_in = k; base_in = b; count_in = c; start = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end while (!out_valid && cyc < 3000);
    chk("latency", 64'(cyc), 64'(exp_lat));
  endtask

  task automatic wait_drain(input string nm);
    int c = 0;
    while ((sb.size() != 0 || !ready) && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    chk(nm, 64'(sb.size() == 0 && ready), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: out_k=0x%0h result=0x%0h, want no output", out_k, result);
      end else begin
        chk("out_k", 64'(out_k), 64'(sb[0].k));
        chk("result", 64'(result), 64'(sb[0].r));
        chk("last", 64'(last), 64'(sb[0].l));
        if (out_ready) sb.delete(0);
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b1;
    k_in = '0; base_in = '0; count_in = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_out_k", 64'(out_k), 64'd0);

    // first start right after reset release; one base-2 digit
    @(negedge clk); rst_n = 1'b1;
    push(32'd1, 32'h8000_0000, 1'b1);
    run_lat(32'd1, 4'd2, 16'd1, 43);
    wait_drain("drain_b2_k1");

    push(32'd1, 32'h8000_0000, 1'b0);
    push(32'd2, 32'h4000_0000, 1'b0);
    push(32'd3, 32'hC000_0000, 1'b1);
    start_burst(32'd1, 4'd2, 16'd3);
    wait_drain("drain_b2_burst3");

    push(32'd1, 32'h5555_5555, 1'b1);
    start_burst(32'd1, 4'd3, 16'd1);
    wait_drain("drain_b3_k1");

    push(32'd5, 32'hC71C_71C7, 1'b1);
    start_burst(32'd5, 4'd3, 16'd1);
    wait_drain("drain_b3_k5");

    push(32'd1, 32'h2492_4924, 1'b1);
    start_burst(32'd1, 4'd7, 16'd1);
    wait_drain("drain_b7_k1");

    // count 0 behaves as a single term
    push(32'd2, 32'hAAAA_AAAA, 1'b1);
    start_burst(32'd2, 4'd3, 16'd0);
    wait_drain("drain_count0");

    // k=0 skips the divider entirely
    push(32'd0, 32'h0, 1'b1);
    run_lat(32'd0, 4'd5, 16'd1, 2);
    wait_drain("drain_k0");

    // index wrap with consumer stalled for 10 cycles
    out_ready = 1'b0;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    push(32'd0, 32'h0, 1'b1);
    start_burst(32'hFFFF_FFFF, 4'd2, 16'd2);
    c = 0;
    while (!out_valid && c < 3000) begin @(posedge clk); #1; c++; end
    chk("stall_valid", 64'(out_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_hold", 64'(out_valid), 64'd1);
    chk("stall_queue", 64'(sb.size()), 64'd2);
    out_ready = 1'b1;
    wait_drain("drain_wrap");

    // invalid base: one-cycle error pulse, no burst
    k_in = 32'd4; base_in = 4'd1; count_in = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", 64'(error), 64'd1);
    chk("err_ready", 64'(ready), 64'd1);
    chk("err_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("err_clear", 64'(error), 64'd0);
    repeat (50) @(posedge clk);
    #1;

    // second start while busy must be ignored
    push(32'd1, 32'h5555_5555, 1'b1);
    start_burst(32'd1, 4'd3, 16'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_ready", 64'(ready), 64'd0);
    start_burst(32'd7, 4'd2, 16'd1);
    wait_drain("drain_busy");
    repeat (200) @(posedge clk);
    #1;

    // reset in the middle of DIV abandons the burst
    start_burst(32'd3, 4'd2, 16'd1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_out_k", 64'(out_k), 64'd0);
    chk("mid_rst_last", 64'(last), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(ready), 64'd1);
    push(32'd1, 32'h8000_0000, 1'b1);
    run_lat(32'd1, 4'd2, 16'd1, 43);
    wait_drain("drain_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
